bram_burst_reader: RTL and testbench
====================================

// Module: bram_burst_reader
// PURPOSE
//  Downstream companion of the BRAM base-address stage. It takes a base address and a word
//  count, then reads that many consecutive 32-bit words from the PS-shared BRAM port.
//  Read data is buffered in a small FIFO and presented to the U-Net datapath as a
//  valid/ready stream. Sits between the AXI-BRAM controller's port B and the layer loader.
// PARAMETERS
//  RD_LAT      1   BRAM read latency in cycles (legal 1..2); ram_rd_data valid RD_LAT cycles after ram_en
//  FIFO_DEPTH  4   output FIFO entries, power of 2, >= RD_LAT+1
//  LEN_W       16  width of word-count input
// PORTS
//  clk          in   1      system clock
//  rst_n        in   1      asynchronous active-low reset
//  start        in   1      1-cycle request; sampled only in IDLE
//  base_addr    in   32     byte address of first word (typically ram_addr of base-address stage)
//  len          in   LEN_W  number of 32-bit words to read
//  busy         out  1      high from accepted start until done pulse inclusive
//  done         out  1      1-cycle pulse: burst finished, all words accepted downstream
//  ram_clk      out  1      = clk
//  ram_rst      out  1      constant 0
//  ram_en       out  1      registered; high only on read-issue cycles
//  ram_addr     out  32     registered byte address of issued read
//  ram_rd_data  in   32     BRAM read data
//  m_data       out  32     stream data (FIFO head)
//  m_valid      out  1      stream valid
//  m_ready      in   1      stream ready; transfer when m_valid & m_ready
//  checksum     out  32     (CHECKSUM_EN only) running sum of transferred words
// BEHAVIOUR
//  Reset: busy=0, done=0, ram_en=0, ram_addr=0, m_valid=0, m_data=0, FIFO empty, checksum=0.
//  FSM: IDLE -> READ (start & len!=0) -> DRAIN (all len reads issued) -> IDLE (last word transferred; done=1).
//   IDLE, start & len==0: done pulses next cycle, busy high that cycle only, no BRAM access.
//   start while not IDLE: ignored, no effect on running burst.
//  Issue: in READ, one read per cycle when credit = FIFO free slots - reads in flight > 0.
//   issue k (k=0..len-1): ram_en=1, ram_addr = base_addr + 4*k, mod 2^32 (wraps 0xFFFFFFFC->0).
//   base_addr, len latched at start; later input changes ignored.
//  Return: valid token pipeline RD_LAT deep; ram_rd_data written to FIFO exactly RD_LAT cycles after issue.
//   Credit rule guarantees FIFO never overflows; no read data is ever dropped.
//  Latency: start sampled at edge 0 -> ram_en high after edge 1 -> m_valid high after edge 2+RD_LAT.
//  Throughput: m_ready held 1 -> one word/cycle sustained, no bubbles after first word.
//  Stream: m_data stable while m_valid & !m_ready; FIFO in-order; simultaneous write+read at full allowed.
//  done asserted the cycle after the last handshake; busy drops with done's falling edge (IDLE next).
//  Back-to-back: start in the cycle done is high is ignored (still busy); accepted next cycle.
//  rst_n low mid-burst: immediate return to reset values, FIFO and in-flight tokens discarded.
// CONFIGURATION
//  CHECKSUM_EN defined: checksum port exists; cleared on accepted start, += m_data (mod 2^32) per
//   handshake; holds final value after done until next accepted start.
//  CHECKSUM_EN undefined: no checksum port, no adder; all other behaviour identical.
// TESTING
//  T1 base=0x1000,len=4,m_ready=1,RD_LAT=1 -> ram_addr 0x1000,0x1004,0x1008,0x100C consecutive; 4 words in order; done 1 pulse.
//  T2 len=8, m_ready=0 for 20 cycles then 1 -> exactly FIFO_DEPTH reads issued and then stall; all 8 words delivered; no loss.
//  T3 len=0 start -> done next cycle, ram_en never high, m_valid never high.
//  T4 base=0xFFFFFFF8,len=3 -> addresses 0xFFFFFFF8,0xFFFFFFFC,0x00000000.
//  T5 rst_n low at cycle 3 of len=16 burst -> all outputs reset values next sample; new start after release runs cleanly.
//  T6 CHECKSUM_EN, data 1,2,3,4, RD_LAT=2, random m_ready -> checksum=10 at done; start pulses while busy ignored.

Source files
------------

// File: rtl/bram_burst_reader.sv
// Burst reader: issues len consecutive word reads from a BRAM port and streams the data out
// through a small credit-protected FIFO. Define CHECKSUM_EN to add a running checksum output.
module bram_burst_reader #(
    parameter int unsigned RD_LAT     = 1,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned LEN_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [31:0]      base_addr,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    output logic             done,
    output logic             ram_clk,
    output logic             ram_rst,
    output logic             ram_en,
    output logic [31:0]      ram_addr,
    input  logic [31:0]      ram_rd_data,
    output logic [31:0]      m_data,
    output logic             m_valid,
    input  logic             m_ready
`ifdef CHECKSUM_EN
    ,
    output logic [31:0]      checksum
`endif
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned OW = CW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              ram_en_q, ram_en_d;
    logic [31:0]       ram_addr_q, ram_addr_d;
    logic [31:0]       next_addr_q, next_addr_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  issue_cnt_q, issue_cnt_d;
    logic [LEN_W-1:0]  xfer_cnt_q, xfer_cnt_d;
    logic [RD_LAT-1:0] tok_q, tok_d;
    logic [31:0]       mem_q [FIFO_DEPTH];
    logic [31:0]       mem_d [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              m_valid_q, m_valid_d;
    logic [31:0]       m_data_q, m_data_d;
`ifdef CHECKSUM_EN
    logic [31:0]       checksum_q, checksum_d;
`endif

    logic              pop_c;
    logic              push_c;
    logic [OW-1:0]     inflight_c;
    logic [OW-1:0]     occ_c;
    logic              can_issue_c;

    assign pop_c  = m_valid_q & m_ready;
    assign push_c = tok_q[RD_LAT-1];

    // Occupancy after this edge if nothing new is issued; issue only if a slot remains.
    always_comb begin
        inflight_c = OW'(ram_en_q);
        for (int i = 0; i < RD_LAT; i++) begin
            inflight_c = inflight_c + OW'(tok_q[i]);
        end
        occ_c       = OW'(count_q) + inflight_c - OW'(pop_c);
        can_issue_c = (occ_c < OW'(FIFO_DEPTH));
    end

    // Burst control FSM: next state, read issue and status pulses.
    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        ram_en_d    = 1'b0;
        ram_addr_d  = ram_addr_q;
        next_addr_d = next_addr_q;
        len_d       = len_q;
        issue_cnt_d = issue_cnt_q;
        xfer_cnt_d  = xfer_cnt_q;
`ifdef CHECKSUM_EN
        checksum_d  = checksum_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    len_d       = len;
                    next_addr_d = base_addr;
                    issue_cnt_d = '0;
                    xfer_cnt_d  = '0;
                    busy_d      = 1'b1;
`ifdef CHECKSUM_EN
                    checksum_d  = '0;
`endif
                    if (len == '0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_READ;
                    end
                end
            end
            S_READ: begin
                if (can_issue_c) begin
                    ram_en_d    = 1'b1;
                    ram_addr_d  = next_addr_q;
                    next_addr_d = next_addr_q + 32'd4;
                    issue_cnt_d = issue_cnt_q + LEN_W'(1);
                    if (issue_cnt_q == len_q - LEN_W'(1)) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (pop_c && (xfer_cnt_q == len_q - LEN_W'(1))) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        if (pop_c) begin
            xfer_cnt_d = xfer_cnt_q + LEN_W'(1);
`ifdef CHECKSUM_EN
            checksum_d = checksum_q + m_data_q;
`endif
        end
    end

    // Return token pipeline and output FIFO; head word is registered onto m_data.
    always_comb begin
        tok_d[0] = ram_en_q;
        for (int i = 1; i < RD_LAT; i++) begin
            tok_d[i] = tok_q[i-1];
        end

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_c) begin
            mem_d[wr_ptr_q] = ram_rd_data;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        count_d   = count_q + CW'(push_c) - CW'(pop_c);
        m_valid_d = (count_d != '0);
        m_data_d  = m_valid_d ? mem_d[rd_ptr_d] : m_data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ram_en_q    <= 1'b0;
            ram_addr_q  <= '0;
            next_addr_q <= '0;
            len_q       <= '0;
            issue_cnt_q <= '0;
            xfer_cnt_q  <= '0;
            tok_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            m_valid_q   <= 1'b0;
            m_data_q    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
`ifdef CHECKSUM_EN
            checksum_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            ram_en_q    <= ram_en_d;
            ram_addr_q  <= ram_addr_d;
            next_addr_q <= next_addr_d;
            len_q       <= len_d;
            issue_cnt_q <= issue_cnt_d;
            xfer_cnt_q  <= xfer_cnt_d;
            tok_q       <= tok_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            m_valid_q   <= m_valid_d;
            m_data_q    <= m_data_d;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
`ifdef CHECKSUM_EN
            checksum_q  <= checksum_d;
`endif
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign ram_clk  = clk;
    assign ram_rst  = 1'b0;
    assign ram_en   = ram_en_q;
    assign ram_addr = ram_addr_q;
    assign m_data   = m_data_q;
    assign m_valid  = m_valid_q;
`ifdef CHECKSUM_EN
    assign checksum = checksum_q;
`endif

endmodule

// File: tb/tb_bram_burst_reader.sv
// Directed bench for bram_burst_reader: a table of bursts plus hand-written reset and
// back-to-back sequences, against a behavioural BRAM whose word is a function of its address.
module tb_bram_burst_reader;

    localparam int unsigned RD_LAT     = 1;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned LEN_W      = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [31:0]      base_addr = '0;
    logic [LEN_W-1:0] len = '0;
    logic             busy, done, ram_clk, ram_rst, ram_en;
    logic [31:0]      ram_addr, ram_rd_data, m_data;
    logic             m_valid;
    logic             m_ready = 1'b0;
`ifdef CHECKSUM_EN
    logic [31:0]      checksum;
`endif

    bram_burst_reader #(
        .RD_LAT(RD_LAT), .FIFO_DEPTH(FIFO_DEPTH), .LEN_W(LEN_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .len(len),
        .busy(busy), .done(done), .ram_clk(ram_clk), .ram_rst(ram_rst),
        .ram_en(ram_en), .ram_addr(ram_addr), .ram_rd_data(ram_rd_data),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready)
`ifdef CHECKSUM_EN
        , .checksum(checksum)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] bram_word(input logic [31:0] a);
        return a ^ 32'hDEAD_BEEF;
    endfunction

    // Behavioural BRAM with RD_LAT cycles of read latency.
    logic [31:0] rd_pipe [RD_LAT];
    always @(posedge clk) begin
        if (ram_en) rd_pipe[0] <= bram_word(ram_addr);
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign ram_rd_data = rd_pipe[RD_LAT-1];

    // Monitor, sampled on the falling edge.
    logic        mon_clr = 1'b0;
    logic [31:0] iss_q[$];
    logic [31:0] got_q[$];
    int          first_iss, first_hs, last_hs, done_cyc, done_cnt, mvalid_cnt, stab_err;
    logic        busy_at_done, busy_after, prev_stall;
    logic [31:0] prev_data, chk_at_done;

    always @(negedge clk) begin
        if (mon_clr) begin
            iss_q.delete(); got_q.delete();
            first_iss = -1; first_hs = -1; last_hs = -1; done_cyc = -1;
            done_cnt = 0; mvalid_cnt = 0; stab_err = 0;
            busy_at_done = 1'b0; busy_after = 1'b1; prev_stall = 1'b0;
            prev_data = '0; chk_at_done = '0;
        end else begin
            if (ram_en) begin
                if (first_iss < 0) first_iss = cyc;
                iss_q.push_back(ram_addr);
            end
            if (m_valid) mvalid_cnt++;
            if (m_valid && m_ready) begin
                if (first_hs < 0) first_hs = cyc;
                last_hs = cyc;
                got_q.push_back(m_data);
            end
            if (prev_stall && (m_data != prev_data)) stab_err++;
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            if (done) begin
                done_cnt++;
                done_cyc     = cyc;
                busy_at_done = busy;
`ifdef CHECKSUM_EN
                chk_at_done  = checksum;
`endif
            end
            if ((done_cyc >= 0) && (cyc == done_cyc + 1)) busy_after = busy;
        end
    end

    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic mon_clear();
        mon_clr = 1'b1;
        @(negedge clk);
        #1 mon_clr = 1'b0;
    endtask

    typedef struct {
        logic [31:0] base;
        int          len;
        int          hold;      // cycles with m_ready low after start (0: ready from start)
        int          poke;      // cycle at which a stray start is pulsed (0: none)
        logic [31:0] exp_last;
        int          exp_stall; // reads issued before m_ready rises
    } vec_t;

    vec_t vecs[6];

    task automatic run_vec(input int idx, input vec_t v);
        int t0, cnt, stall_iss, errs;
        logic [31:0] sum;
        string tag;
        tag = $sformatf("v%0d", idx);
        mon_clear();
        @(posedge clk); #1;
        start = 1'b1; base_addr = v.base; len = LEN_W'(v.len); m_ready = (v.hold == 0);
        t0 = cyc;
        @(posedge clk); #1;
        start = 1'b0; base_addr = 32'hBAD0_0000; len = LEN_W'(5);
        cnt = 1; stall_iss = -1;
        while ((done_cnt == 0) && (cnt < 300)) begin
            if (cnt == v.hold) begin
                stall_iss = iss_q.size();
                m_ready   = 1'b1;
            end
            start = (cnt == v.poke);
            @(posedge clk); #1;
            cnt++;
        end
        start = 1'b0;
        check({tag, " done_timeout"}, 32'(cnt < 300), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        check({tag, " issue_count"}, iss_q.size(), v.len);
        check({tag, " word_count"}, got_q.size(), v.len);
        errs = 0;
        sum  = '0;
        for (int k = 0; k < v.len; k++) begin
            if (iss_q[k] != v.base + 32'(4 * k)) errs++;
            if (got_q[k] != bram_word(v.base + 32'(4 * k))) errs++;
            sum = sum + bram_word(v.base + 32'(4 * k));
        end
        check({tag, " addr_data_seq"}, errs, 0);
        check({tag, " done_pulses"}, done_cnt, 1);
        check({tag, " busy_at_done"}, busy_at_done, 1);
        check({tag, " busy_after_done"}, busy_after, 0);
        check({tag, " m_data_stable"}, stab_err, 0);
        if (v.hold > 0) check({tag, " stall_issues"}, stall_iss, v.exp_stall);
        if (v.len == 0) begin
            check({tag, " no_m_valid"}, mvalid_cnt, 0);
            check({tag, " zero_len_done_lat"}, done_cyc - t0, 1);
        end else begin
            check({tag, " first_addr"}, iss_q[0], v.base);
            check({tag, " last_addr"}, iss_q[v.len-1], v.exp_last);
            check({tag, " done_after_last"}, done_cyc - last_hs, 1);
            check({tag, " no_bubbles"}, last_hs - first_hs, v.len - 1);
        end
        if ((v.len > 0) && (v.hold == 0)) begin
            check({tag, " issue_latency"}, first_iss - t0, 2);
            check({tag, " valid_latency"}, first_hs - t0, 2 + RD_LAT + 1);
        end
`ifdef CHECKSUM_EN
        check({tag, " checksum"}, chk_at_done, sum);
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, cnt;
        vecs[0] = '{32'h0000_1000,  4,  0,  0, 32'h0000_100C, 0};
        vecs[1] = '{32'h0000_2000,  8, 20, 10, 32'h0000_201C, FIFO_DEPTH};
        vecs[2] = '{32'hFFFF_FFF8,  3,  0,  0, 32'h0000_0000, 0};
        vecs[3] = '{32'h0000_0000,  0,  0,  0, 32'h0000_0000, 0};
        vecs[4] = '{32'h0000_0040,  2,  5,  0, 32'h0000_0044, 2};
        vecs[5] = '{32'h8000_0000, 16,  0,  3, 32'h8000_003C, 0};

        // Reset values.
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst ram_en", ram_en, 0);
        check("rst ram_addr", ram_addr, 0);
        check("rst m_valid", m_valid, 0);
        check("rst m_data", m_data, 0);
        check("ram_rst", ram_rst, 0);
`ifdef CHECKSUM_EN
        check("rst checksum", checksum, 0);
`endif

        // Asynchronous reset in the middle of a 16-word burst.
        mon_clear();
        @(posedge clk); #1;
        start = 1'b1; base_addr = 32'h0000_7000; len = LEN_W'(16); m_ready = 1'b1;
        t0 = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("mid busy", busy, 1);
        check("mid m_valid", m_valid, 1);
        rst_n = 1'b0;
        #1;
        check("arst busy", busy, 0);
        check("arst ram_en", ram_en, 0);
        check("arst ram_addr", ram_addr, 0);
        check("arst m_valid", m_valid, 0);
        check("arst m_data", m_data, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        mon_clear();
        repeat (5) @(posedge clk);
        #1;
        check("post_rst no_valid", mvalid_cnt, 0);
        check("post_rst no_issue", iss_q.size(), 0);

        for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

        // Start during the done cycle is ignored; start one cycle later is taken.
        mon_clear();
        @(posedge clk); #1;
        start = 1'b1; base_addr = 32'h0000_0100; len = LEN_W'(1); m_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cnt = 0;
        while (!done && (cnt < 50)) begin
            @(posedge clk); #1;
            cnt++;
        end
        check("b2b first_done", done, 1);
        start = 1'b1; base_addr = 32'h0000_5000; len = LEN_W'(2);
        @(posedge clk); #1;
        check("b2b idle_busy", busy, 0);
        @(posedge clk); #1;
        start = 1'b0;
        check("b2b accepted", busy, 1);
        cnt = 0;
        while (!done && (cnt < 50)) begin
            @(posedge clk); #1;
            cnt++;
        end
        check("b2b second_done", done, 1);
        repeat (3) @(posedge clk);
        #1;
        check("b2b done_pulses", done_cnt, 2);
        check("b2b issues", iss_q.size(), 3);
        check("b2b addr1", iss_q[1], 32'h0000_5000);
        check("b2b addr2", iss_q[2], 32'h0000_5004);
        check("b2b word2", got_q[2], bram_word(32'h0000_5004));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
